// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES-192 job scheduler.
package aes_sched_pkg;

    localparam int KSEL_W          = 2;
    localparam int BLK_W           = 128;
    localparam int TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DRAIN,
        ST_RUN,
        ST_RESP
    } state_e;

endpackage

// File: rtl/aes_job_sched_if.sv
// Requester and engine bundle of the AES job scheduler; slave = scheduler, master = environment.
interface aes_job_sched_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]                                 req_valid_i;
    logic [NREQ-1:0]                                 req_ready_o;
    logic [NREQ-1:0][aes_sched_pkg::BLK_W-1:0]       req_pt_i;
    logic [NREQ-1:0][aes_sched_pkg::KSEL_W-1:0]      req_ksel_i;
    logic [NREQ-1:0]                                 rsp_valid_o;
    logic [NREQ-1:0]                                 rsp_ready_i;
    logic [aes_sched_pkg::BLK_W-1:0]                 rsp_ct_o;
    logic                                            rsp_err_o;
    logic                                            aes_start_o;
    logic [aes_sched_pkg::BLK_W-1:0]                 aes_pt_o;
    logic [aes_sched_pkg::KSEL_W-1:0]                aes_ksel_o;
    logic [aes_sched_pkg::BLK_W-1:0]                 aes_ct_i;
    logic                                            aes_valid_i;

    modport slave (
        input  req_valid_i, req_pt_i, req_ksel_i, rsp_ready_i, aes_ct_i, aes_valid_i,
        output req_ready_o, rsp_valid_o, rsp_ct_o, rsp_err_o, aes_start_o, aes_pt_o, aes_ksel_o
    );

    modport master (
        output req_valid_i, req_pt_i, req_ksel_i, rsp_ready_i, aes_ct_i, aes_valid_i,
        input  req_ready_o, rsp_valid_o, rsp_ct_o, rsp_err_o, aes_start_o, aes_pt_o, aes_ksel_o
    );

endinterface

// File: rtl/rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searching from the slot after the last winner.
// Pointer advances to the winner only when en_i accepts the grant; resets so index 0 wins first.
module rr_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NREQ-1:0]  req_i,
    input  logic             en_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDX_W'((int'(ptr_q) + k) % NREQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

    assign ptr_d = (en_i && found) ? gnt_idx_o : ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= IDX_W'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/aes_job_sched.sv
// Shares one AES-192 engine among NREQ requesters: RR grant, one start pulse, stale-valid drain,
// timeout abort, and a per-requester response held until that requester accepts it.
module aes_job_sched
    import aes_sched_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           lock_i,
    output logic           busy_o,
    aes_job_sched_if.slave bus
);

    localparam int          IDX_W   = $clog2(NREQ);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [BLK_W-1:0]   pt_q, pt_d;
    logic [KSEL_W-1:0]  ksel_q, ksel_d;
    logic [BLK_W-1:0]   ct_q, ct_d;
    logic               err_q, err_d;

    logic               grant_en;
    logic               timeout;
    logic [NREQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]   arb_idx;

    // Ready is combinational in IDLE, so it must be masked while reset is held.
    assign grant_en = (state_q == ST_IDLE) && !lock_i && (|bus.req_valid_i) && !rst_i;
    assign timeout  = (cnt_q == TO_LAST);

    rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (bus.req_valid_i),
        .en_i      (grant_en),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        pt_d    = pt_q;
        ksel_d  = ksel_q;
        ct_d    = ct_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    gnt_d   = arb_idx;
                    pt_d    = bus.req_pt_i[arb_idx];
                    ksel_d  = bus.req_ksel_i[arb_idx];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 16'd1;
                if (timeout) begin
                    ct_d    = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (!bus.aes_valid_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 16'd1;
                // A result arriving on the expiry cycle still wins over the abort.
                if (bus.aes_valid_i) begin
                    ct_d    = bus.aes_ct_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timeout) begin
                    ct_d    = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            pt_q    <= '0;
            ksel_q  <= '0;
            ct_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            pt_q    <= pt_d;
            ksel_q  <= ksel_d;
            ct_q    <= ct_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready_o = grant_en ? arb_gnt : '0;
    assign bus.aes_start_o = (state_q == ST_START);
    assign bus.aes_pt_o    = pt_q;
    assign bus.aes_ksel_o  = ksel_q;
    assign bus.rsp_valid_o = (state_q == ST_RESP) ? (NREQ'(1) << gnt_q) : '0;
    assign bus.rsp_ct_o    = ct_q;
    assign bus.rsp_err_o   = err_q;
    assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: doc/aes_job_sched.md
AES_JOB_SCHED -- requirements
Module: aes_job_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, meaning the number of requesters sharing the AES-192 engine (range 2..4).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning the number of cycles to wait for the engine result before aborting a job.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
REQ-004 The block SHALL have the following requester and control ports.
- lock_i  in  1  register-lock: when 1, no new grant is issued
- req_valid_i  in  NREQ  per-requester job request
- req_ready_o  out  NREQ  per-requester job accept
- req_pt_i  in  NREQ x 128  plaintext per requester
- req_ksel_i  in  NREQ x 2  key-slot select per requester
- rsp_valid_o  out  NREQ  per-requester result valid
- rsp_ready_i  in  NREQ  per-requester result accept
- rsp_ct_o  out  128  ciphertext (shared bus)
- rsp_err_o  out  1  result is a timeout abort
REQ-005 The block SHALL have the following engine-side ports.
- aes_start_o  out  1  engine start
- aes_pt_o  out  128  engine plaintext
- aes_ksel_o  out  2  engine key select
- aes_ct_i  in  128  engine ciphertext
- aes_valid_i  in  1  engine out_valid
- busy_o  out  1  a job is in flight

Function
REQ-006 The FSM SHALL have states IDLE, START, DRAIN, RUN and RESP.
REQ-007 IDLE: when lock_i=0 and any req_valid_i is set, the block SHALL grant by round-robin, starting the search at the index after the last granted requester; the pointer resets to NREQ-1 so that requester 0 is served first.
REQ-008 The grant cycle SHALL pulse req_ready_o[g] for exactly one cycle, register req_pt_i[g] and req_ksel_i[g] into aes_pt_o/aes_ksel_o, and move the FSM to START.
REQ-009 aes_pt_o and aes_ksel_o SHALL hold stable from the cycle after grant until the FSM leaves RESP.
REQ-010 START: aes_start_o SHALL be 1 for exactly one cycle, and the FSM SHALL then move to DRAIN.
REQ-011 DRAIN: the block SHALL wait for aes_valid_i=0, which discards a stale valid left by a previous job, then move to RUN.
REQ-012 RUN: on aes_valid_i=1 the block SHALL capture aes_ct_i into rsp_ct_o, clear rsp_err_o and move to RESP.
REQ-013 A 16-bit timeout counter SHALL clear on START and increment in DRAIN and RUN; when it reaches TIMEOUT_CYC-1, the FSM SHALL enter RESP with rsp_err_o=1 and rsp_ct_o=0.
REQ-014 RESP: rsp_valid_o[g] SHALL be 1 only for the granted index g, and SHALL hold with rsp_ct_o and rsp_err_o stable until rsp_ready_i[g]=1; the FSM SHALL then return to IDLE in the next cycle.
REQ-015 rsp_valid_o SHALL be 0 for every non-granted index; rsp_ready_i on a non-granted index SHALL be ignored.
REQ-016 Minimum job latency SHALL be grant to rsp_valid = 3 cycles plus engine latency; back-to-back jobs SHALL have exactly one IDLE cycle between them.
REQ-017 lock_i rising mid-job SHALL NOT abort the job; it only blocks the next grant.
REQ-018 Deassertion of req_valid_i after grant SHALL NOT affect the job in flight.
REQ-019 busy_o SHALL be 1 in every state other than IDLE.
REQ-020 aes_valid_i=1 in the same cycle as timeout expiry SHALL take the result path, not the error path.

Reset
REQ-021 On rst_i=1, the block SHALL asynchronously force IDLE, with req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_ct_o=0, aes_start_o=0, aes_pt_o=0, aes_ksel_o=0, busy_o=0, the timeout counter at 0 and the RR pointer at NREQ-1.
REQ-022 A reset mid-job SHALL drop the job silently, with no response issued after reset release.

Structure
REQ-023 Package aes_sched_pkg SHALL hold the FSM state enum, the KSEL_W=2 and BLK_W=128 constants, and the TIMEOUT_CYC default.
REQ-024 The round-robin arbiter SHALL be a sub-module rr_arb (NREQ requests, one-hot grant, pointer update on an enable input).

Verification
REQ-025 The bench SHALL cover single job: req0 with pt=0x00112233_44556677_8899AABB_CCDDEEFF and ksel=1, engine valid after 12 cycles -> rsp_valid_o[0] with the engine ct, rsp_err_o=0, aes_start_o pulsed exactly once, aes_ksel_o=1.
REQ-026 The bench SHALL cover contention: req0 and req1 asserted together and held -> grants in order 0,1,0,1 over 4 jobs, one IDLE cycle between jobs.
REQ-027 The bench SHALL cover stale valid: aes_valid_i held 1 from before START and dropped 3 cycles later, then re-asserted -> only the re-assertion is captured.
REQ-028 The bench SHALL cover timeout: the engine never asserts valid, TIMEOUT_CYC=16 -> rsp_err_o=1 and rsp_ct_o=0, 17 cycles after START.
REQ-029 The bench SHALL cover backpressure and lock: rsp_ready_i held 0 for 5 cycles -> rsp outputs stable; lock_i=1 with req1 pending -> no req_ready_o until lock_i=0.
REQ-030 The bench SHALL cover reset in RUN: rst_i pulsed -> all outputs 0 in the same cycle, no rsp_valid_o after release, and the next grant goes to req0.
